// File: rtl/day_display_scan_pkg.sv
// day_display_scan_pkg: shared watch letter codes and seven-segment patterns
package day_display_scan_pkg;

    typedef logic [3:0] letter_t;
    typedef logic [6:0] seg_t;

    localparam letter_t C_SPACE = 4'd0;
    localparam letter_t C_A     = 4'd1;
    localparam letter_t C_D     = 4'd2;
    localparam letter_t C_E     = 4'd3;
    localparam letter_t C_F     = 4'd4;
    localparam letter_t C_H     = 4'd5;
    localparam letter_t C_I     = 4'd6;
    localparam letter_t C_N     = 4'd7;
    localparam letter_t C_O     = 4'd8;
    localparam letter_t C_P     = 4'd9;
    localparam letter_t C_R     = 4'd10;
    localparam letter_t C_S     = 4'd11;
    localparam letter_t C_T     = 4'd12;
    localparam letter_t C_U     = 4'd13;

    // segment order {a,b,c,d,e,f,g}, active-high
    localparam seg_t SEG_SPACE = 7'b0000000;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_D     = 7'b0111101;
    localparam seg_t SEG_E     = 7'b1001111;
    localparam seg_t SEG_F     = 7'b1000111;
    localparam seg_t SEG_H     = 7'b0110111;
    localparam seg_t SEG_I     = 7'b0110000;
    localparam seg_t SEG_N     = 7'b0010101;
    localparam seg_t SEG_O     = 7'b1111110;
    localparam seg_t SEG_P     = 7'b1100111;
    localparam seg_t SEG_R     = 7'b0000101;
    localparam seg_t SEG_S     = 7'b1011011;
    localparam seg_t SEG_T     = 7'b0001111;
    localparam seg_t SEG_U     = 7'b0111110;
    localparam seg_t SEG_BAD   = 7'b0000001;

    localparam logic [3:0] DIG_OFF = 4'b1111;

endpackage

// File: rtl/letter_seg_decode.sv
// letter_seg_decode: combinational letter code to seven-segment pattern
module letter_seg_decode
    import day_display_scan_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg
);

    // unused codes light only segment g as a visible error marker
    always_comb begin
        seg = SEG_BAD;
        case (code)
            C_SPACE: seg = SEG_SPACE;
            C_A:     seg = SEG_A;
            C_D:     seg = SEG_D;
            C_E:     seg = SEG_E;
            C_F:     seg = SEG_F;
            C_H:     seg = SEG_H;
            C_I:     seg = SEG_I;
            C_N:     seg = SEG_N;
            C_O:     seg = SEG_O;
            C_P:     seg = SEG_P;
            C_R:     seg = SEG_R;
            C_S:     seg = SEG_S;
            C_T:     seg = SEG_T;
            C_U:     seg = SEG_U;
            default: seg = SEG_BAD;
        endcase
    end

endmodule

// File: rtl/day_display_scan.sv
// day_display_scan: 4-digit multiplexed day-name display scanner; DAY_DISP_BLINK_EN enables frame blinking
module day_display_scan
    import day_display_scan_pkg::*;
#(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
)(
    input  logic       clk,
    input  logic       resetTime,
    input  logic [3:0] FirstLetter,
    input  logic [3:0] SecondLetter,
    input  logic [3:0] ThirdLetter,
    input  logic [3:0] FourthLetter,
    input  logic       load,
    input  logic       en,
    input  logic       blink,
    output logic [6:0] seg,
    output logic [3:0] dig_n
);

    localparam int PW = $clog2(SCAN_DIV);

    logic [PW-1:0]     presc, presc_nx;
    logic [1:0]        idx, idx_nx;
    letter_t [3:0]     shadow, shadow_nx;
    logic              tc;
    logic              blank;
    logic              dark;
    seg_t              seg_nx;

    // next scan position and shadow contents; outputs are derived from these so load and advance land together
    always_comb begin
        tc        = presc == PW'(SCAN_DIV - 1);
        presc_nx  = !en ? presc : tc ? '0 : presc + 1'b1;
        idx_nx    = (en && tc) ? idx + 2'd1 : idx;
        shadow_nx = load ? {FourthLetter, ThirdLetter, SecondLetter, FirstLetter} : shadow;
        dark      = !en || presc_nx == '0 || blank;
    end

    letter_seg_decode u_decode (
        .code (shadow_nx[idx_nx]),
        .seg  (seg_nx)
    );

`ifdef DAY_DISP_BLINK_EN
    localparam int FW = $clog2(2 * BLINK_DIV) < 1 ? 1 : $clog2(2 * BLINK_DIV);

    logic [FW-1:0] frame, frame_nx;

    // frames counted on each 3->0 wrap while blinking; second half of the period is dark
    always_comb begin
        frame_nx = frame;
        if (!blink)
            frame_nx = '0;
        else if (en && tc && idx == 2'd3)
            frame_nx = (frame == FW'(2 * BLINK_DIV - 1)) ? '0 : frame + 1'b1;
        blank = frame_nx >= FW'(BLINK_DIV);
    end

    // blink frame counter
    always_ff @(posedge clk or posedge resetTime) begin
        if (resetTime)
            frame <= '0;
        else
            frame <= frame_nx;
    end
`else
    logic unused_blink;

    assign unused_blink = blink;
    assign blank        = 1'b0;
`endif

    // scan state, shadow letters and registered display outputs
    always_ff @(posedge clk or posedge resetTime) begin
        if (resetTime) begin
            presc  <= '0;
            idx    <= '0;
            shadow <= {4{C_SPACE}};
            dig_n  <= DIG_OFF;
            seg    <= SEG_SPACE;
        end else begin
            presc  <= presc_nx;
            idx    <= idx_nx;
            shadow <= shadow_nx;
            dig_n  <= dark ? DIG_OFF : ~(4'b0001 << idx_nx);
            seg    <= dark ? SEG_SPACE : seg_nx;
        end
    end

endmodule

// File: tb/tb_day_display_scan.sv
// tb_day_display_scan: directed bench with a time-based display model
module tb_day_display_scan;

    localparam int SD = 4;
    localparam int BD = 1;

    logic       clk = 1'b0;
    logic       resetTime = 1'b0;
    logic       load = 1'b0;
    logic       en = 1'b0;
    logic       blink = 1'b0;
    logic [3:0] l0 = '0, l1 = '0, l2 = '0, l3 = '0;
    logic [6:0] seg;
    logic [3:0] dig_n;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    day_display_scan #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .clk          (clk),
        .resetTime    (resetTime),
        .FirstLetter  (l0),
        .SecondLetter (l1),
        .ThirdLetter  (l2),
        .FourthLetter (l3),
        .load         (load),
        .en           (en),
        .blink        (blink),
        .seg          (seg),
        .dig_n        (dig_n)
    );

    logic [6:0] font [0:15] = '{
        7'b0000000, 7'b1110111, 7'b0111101, 7'b1001111,
        7'b1000111, 7'b0110111, 7'b0110000, 7'b0010101,
        7'b1111110, 7'b1100111, 7'b0000101, 7'b1011011,
        7'b0001111, 7'b0111110, 7'b0000001, 7'b0000001
    };

    int         t = 0;
    int         bf = 0;
    int         sh [4] = '{0, 0, 0, 0};
    int         m_digit;
    bit         m_dark;
    logic [3:0] exp_dig = 4'hF;
    logic [6:0] exp_seg = '0;

    // model: t counts enabled clocks since reset; slot, digit and frame follow by division
    always @(posedge clk or posedge resetTime) begin
        if (resetTime) begin
            t = 0;
            bf = 0;
            for (int i = 0; i < 4; i++) sh[i] = 0;
            exp_dig = 4'hF;
            exp_seg = '0;
        end else begin
            if (load) begin
                sh[0] = int'(l0);
                sh[1] = int'(l1);
                sh[2] = int'(l2);
                sh[3] = int'(l3);
            end
            if (en) begin
                t++;
                if (t % (4 * SD) == 0 && blink) bf++;
            end
            if (!blink) bf = 0;
            m_digit = (t / SD) % 4;
            m_dark = !en || (t % SD == 0);
`ifdef DAY_DISP_BLINK_EN
            m_dark = m_dark || ((bf / BD) % 2 == 1);
`endif
            exp_dig = m_dark ? 4'hF : ~(4'b0001 << m_digit);
            exp_seg = m_dark ? 7'b0 : font[sh[m_digit]];
        end
    end

    always @(negedge clk) begin
        compared++;
        if (dig_n !== exp_dig || seg !== exp_seg) begin
            mismatched++;
            $display("FAIL scan @%0t: dig_n=%b seg=%b expected dig_n=%b seg=%b", $time, dig_n, seg, exp_dig, exp_seg);
        end
    end

    task automatic lit(input string nm, input logic [3:0] d, input logic [6:0] s);
        compared++;
        if (dig_n !== d || seg !== s) begin
            mismatched++;
            $display("FAIL %s @%0t: dig_n=%b seg=%b expected dig_n=%b seg=%b", nm, $time, dig_n, seg, d, s);
        end
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        #1 resetTime = 1'b1;
        #1 lit("reset", 4'hF, 7'b0);
        run(1);
        resetTime = 1'b0;
        l0 = 4'd12; l1 = 4'd13; l2 = 4'd3; l3 = 4'd0;
        load = 1'b1;
        en = 1'b1;
        run(1); load = 1'b0; lit("tue_t", 4'b1110, 7'b0001111);
        run(3); lit("tue_dead", 4'hF, 7'b0);
        run(1); lit("tue_u", 4'b1101, 7'b0111110);
        run(4); lit("tue_e", 4'b1011, 7'b1001111);
        run(4); lit("tue_sp", 4'b0111, 7'b0000000);
        run(4); lit("tue_wrap", 4'b1110, 7'b0001111);
        l0 = 4'd11; l1 = 4'd1; l2 = 4'd12; l3 = 4'd0;
        run(4); lit("no_load", 4'b1101, 7'b0111110);
        run(2); load = 1'b1;
        run(1); load = 1'b0; lit("load_dead", 4'hF, 7'b0);
        run(1); lit("sat_t", 4'b1011, 7'b0001111);
        run(8); lit("sat_s", 4'b1110, 7'b1011011);
        run(4); lit("sat_a", 4'b1101, 7'b1110111);
        run(1); en = 1'b0;
        run(1); lit("en_off", 4'hF, 7'b0);
        run(9); en = 1'b1;
        run(1); lit("en_resume", 4'b1101, 7'b1110111);
        run(1); lit("en_next", 4'hF, 7'b0);
        l0 = 4'd14; l1 = 4'd15; l2 = 4'd6; l3 = 4'd9;
        load = 1'b1;
        run(1); load = 1'b0; lit("code_i", 4'b1011, 7'b0110000);
        run(4); lit("code_p", 4'b0111, 7'b1100111);
        run(4); lit("code14", 4'b1110, 7'b0000001);
        run(4); lit("code15", 4'b1101, 7'b0000001);
        run(5);
        resetTime = 1'b1;
        #1 lit("rst_now", 4'hF, 7'b0);
        run(1); lit("rst_hold", 4'hF, 7'b0);
        resetTime = 1'b0;
        l0 = 4'd12; l1 = 4'd13; l2 = 4'd3; l3 = 4'd0;
        load = 1'b1;
        run(1); load = 1'b0; lit("rst_first", 4'b1110, 7'b0001111);
        blink = 1'b1;
        run(16);
`ifdef DAY_DISP_BLINK_EN
        lit("blink_dark", 4'hF, 7'b0);
`else
        lit("blink_ignored", 4'b1110, 7'b0001111);
`endif
        run(16); lit("blink_lit", 4'b1110, 7'b0001111);
        blink = 1'b0;
        run(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/day_display_scan.md
DAY_DISPLAY_SCAN -- requirements
Module: day_display_scan

Interface
REQ-001 SHALL have parameter: SCAN_DIV, default 1000, clocks each digit is addressed (min 2).
REQ-002 SHALL have parameter: BLINK_DIV, default 64, full scan frames per blink half-period (min 1).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: resetTime  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have ports: FirstLetter, SecondLetter, ThirdLetter, FourthLetter  input  4 each  letter codes from the day-name generator.
REQ-006 SHALL have port: load  input  1  single-cycle strobe; capture all four letters.
REQ-007 SHALL have port: en  input  1  scan enable.
REQ-008 SHALL have port: blink  input  1  blink request, asserted during set mode.
REQ-009 SHALL have port: seg  output  7  segments {a,b,c,d,e,f,g}, active-high.
REQ-010 SHALL have port: dig_n  output  4  one-hot digit select, active-low; bit0 = FirstLetter position.

Function
REQ-011 SHALL decode letter codes to segments: SPACE(0)=0000000, A(1)=1110111, D(2)=0111101, E(3)=1001111, F(4)=1000111, H(5)=0110111, I(6)=0110000, N(7)=0010101, O(8)=1111110, P(9)=1100111, R(10)=0000101, S(11)=1011011, T(12)=0001111, U(13)=0111110; codes 14-15 SHALL show 0000001.
REQ-012 SHALL capture all four letters into shadow registers atomically on a clk edge with load=1; the display SHALL use only the shadow values.
REQ-013 SHALL hold the shadow registers unchanged while load=0; letter-input changes SHALL NOT reach seg without load.
REQ-014 SHALL run a prescaler 0..SCAN_DIV-1 while en=1; at terminal count it SHALL wrap to 0 and advance the digit index 0->1->2->3->0.
REQ-015 SHALL drive dig_n=1111 (dead time) for exactly one clock at prescaler value 0 of every digit slot, then assert dig_n bit[index] low for the remaining SCAN_DIV-1 clocks.
REQ-016 SHALL register seg and dig_n: outputs reflect index and shadow state with one clock latency.
REQ-017 SHALL, when load coincides with a digit advance, show the newly loaded letter in the new slot.
REQ-018 SHALL, when en=0, freeze prescaler and index and force dig_n=1111 and seg=0000000 from the next clock; on en returning to 1, scanning SHALL resume from the frozen state.
REQ-019 SHALL count one frame per index wrap 3->0.

Reset
REQ-020 SHALL on resetTime=1 immediately set shadow letters to SPACE, prescaler 0, index 0, frame/blink counters 0, dig_n=1111, seg=0000000.
REQ-021 SHALL, when reset is asserted mid-slot, discard the slot; after release the first active digit SHALL be digit 0 following the dead-time clock.

Configuration
REQ-022 SHALL, with DAY_DISP_BLINK_EN defined, count frames modulo 2*BLINK_DIV while blink=1 and force dig_n=1111 during the second BLINK_DIV frames; blink=0 SHALL clear the count and display normally.
REQ-023 SHALL, without DAY_DISP_BLINK_EN, keep the blink port but ignore it and omit the frame/blink counters.

Structure
REQ-024 SHALL place the 4-bit letter-code constants (C_SPACE..C_U) and the 7-bit segment patterns in the shared watch package, used by this block and the day-name generator.
REQ-025 SHALL implement the code-to-segment decode as sub-module letter_seg_decode (combinational, 4 in, 7 out); scan, shadow and blink logic SHALL reside in day_display_scan.

Verification
REQ-026 SHALL cover: SCAN_DIV=4, load with codes 12,13,3,0 (TUE) -> per slot one clock of dig_n=1111, then 3 clocks each of 1110/0001111, 1101/0111110, 1011/1001111, 0111/0000000, repeating.
REQ-027 SHALL cover: letters changed to SAT without load -> seg unchanged; load pulse -> next slot shows SAT patterns.
REQ-028 SHALL cover: resetTime pulsed mid digit 2 -> outputs 1111/0000000 immediately; scan restarts at digit 0 after one dead clock.
REQ-029 SHALL cover: en=0 for 10 clocks mid digit 1 -> dark display; en=1 -> digit 1 resumes with remaining count.
REQ-030 SHALL cover: code 14 loaded -> 0000001 in that slot.
REQ-031 SHALL cover: DAY_DISP_BLINK_EN, BLINK_DIV=1, blink=1 -> alternating full frames lit/dark; without macro -> always lit.
